// File: rtl/apb_clk_gate_pkg.sv
// Shared types and constants for the APB peripheral clock-gating controller.
package apb_clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_OFF   = 2'd0,
    CG_RUN   = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int DEF_NUM_SLAVES  = 8;
  localparam int DEF_IDLE_CYCLES = 64;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int WAKE_CNT_W      = 4;

  function automatic bit idle_cycles_ok(input int idle_cycles, input int cnt_width);
    return (idle_cycles >= 1) && (idle_cycles <= (1 << cnt_width) - 1);
  endfunction

  function automatic bit wake_cycles_ok(input int wake_cycles);
    return (wake_cycles >= 1) && (wake_cycles <= (1 << WAKE_CNT_W) - 1);
  endfunction

endpackage

// File: rtl/apb_periph_clk_gate_ctrl_slot.sv
// One slave's gating FSM: idle counter, wake stall counter, registered clock
// enable and the combinational pready-stall / error overrides.
module clk_gate_slot
  import apb_clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_en_i,
  input  logic auto_en_i,
  input  logic psel_i,
  input  logic penable_i,
  input  logic busy_i,
  output logic clk_en_o,
  output logic stall_o,
  output logic err_o,
  output logic gated_next_o
);

  localparam logic [CNT_WIDTH-1:0]  IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  IDLE_MAX  = '1;
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

  cg_state_e              r_state;
  logic [CNT_WIDTH-1:0]   r_idle_cnt;
  logic [WAKE_CNT_W-1:0]  r_wake_cnt;
  logic                   r_clk_en;

  cg_state_e              w_state_next;
  logic [CNT_WIDTH-1:0]   w_idle_next;
  logic [WAKE_CNT_W-1:0]  w_wake_next;
  logic                   w_quiet;

  // Disabling auto-gating counts as activity: it holds RUN and wakes GATED.
  assign w_quiet = auto_en_i & ~(psel_i | busy_i);

  always_comb begin
    w_state_next = r_state;
    w_idle_next  = r_idle_cnt;
    w_wake_next  = r_wake_cnt;
    if (!sw_en_i) begin
      w_state_next = CG_OFF;
    end else begin
      case (r_state)
        CG_RUN: begin
          if (!w_quiet) begin
            w_idle_next = '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            w_state_next = CG_GATED;
            w_idle_next  = '0;
          end else if (r_idle_cnt != IDLE_MAX) begin
            w_idle_next = r_idle_cnt + CNT_WIDTH'(1);
          end
        end
        CG_GATED: begin
          if (!w_quiet) begin
            w_state_next = CG_WAKE;
            w_wake_next  = '0;
          end
        end
        CG_WAKE: begin
          if (r_wake_cnt == WAKE_LAST) begin
            w_state_next = CG_RUN;
            w_idle_next  = '0;
          end else begin
            w_wake_next = r_wake_cnt + WAKE_CNT_W'(1);
          end
        end
        CG_OFF: begin
          w_state_next = CG_WAKE;
          w_wake_next  = '0;
        end
        default: begin
          w_state_next = CG_RUN;
          w_idle_next  = '0;
        end
      endcase
    end
  end

  // clk_en is a function of the next state so it moves on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CG_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_idle_cnt <= w_idle_next;
      r_wake_cnt <= w_wake_next;
      r_clk_en   <= (w_state_next == CG_RUN) || (w_state_next == CG_WAKE);
    end
  end

  assign clk_en_o     = r_clk_en;
  assign stall_o      = psel_i & ((r_state == CG_GATED) || (r_state == CG_WAKE));
  assign err_o        = psel_i & penable_i & (r_state == CG_OFF);
  assign gated_next_o = (w_state_next == CG_GATED) || (w_state_next == CG_OFF);

endmodule

// File: rtl/apb_periph_clk_gate_ctrl.sv
// Per-peripheral automatic clock-gate controller for the APB subsystem:
// one independent gating slot per slave plus a registered all-gated flag.
module apb_periph_clk_gate_ctrl
  import apb_clk_gate_pkg::*;
#(
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SLAVES-1:0] sw_en_i,
  input  logic [NUM_SLAVES-1:0] auto_en_i,
  input  logic [NUM_SLAVES-1:0] psel_i,
  input  logic                  penable_i,
  input  logic [NUM_SLAVES-1:0] busy_i,
  output logic [NUM_SLAVES-1:0] clk_en_o,
  output logic [NUM_SLAVES-1:0] stall_o,
  output logic [NUM_SLAVES-1:0] err_o,
  output logic                  all_gated_o
);

  if (!idle_cycles_ok(IDLE_CYCLES, CNT_WIDTH)) begin : g_bad_idle
    $error("IDLE_CYCLES out of range for CNT_WIDTH");
  end
  if (!wake_cycles_ok(WAKE_CYCLES)) begin : g_bad_wake
    $error("WAKE_CYCLES out of range");
  end

  logic [NUM_SLAVES-1:0] w_gated_next;
  logic                  r_all_gated;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
    clk_gate_slot #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .CNT_WIDTH   (CNT_WIDTH),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .sw_en_i      (sw_en_i[gi]),
      .auto_en_i    (auto_en_i[gi]),
      .psel_i       (psel_i[gi]),
      .penable_i    (penable_i),
      .busy_i       (busy_i[gi]),
      .clk_en_o     (clk_en_o[gi]),
      .stall_o      (stall_o[gi]),
      .err_o        (err_o[gi]),
      .gated_next_o (w_gated_next[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_all_gated <= 1'b0;
    end else begin
      r_all_gated <= &w_gated_next;
    end
  end

  assign all_gated_o = r_all_gated;

endmodule

// File: tb/tb_apb_periph_clk_gate_ctrl.sv
// Directed-vector bench: each row drives one cycle of inputs and queues the
// hand-computed outputs; a negedge monitor pops and compares them.
module tb_apb_periph_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_en   = 8'hFF;
  logic [7:0] auto_en = 8'h01;
  logic [7:0] psel    = 8'h00;
  logic       penable = 1'b0;
  logic [7:0] busy    = 8'h00;
  logic [7:0] clk_en;
  logic [7:0] stall;
  logic [7:0] err;
  logic       all_gated;

  apb_periph_clk_gate_ctrl #(
    .NUM_SLAVES  (8),
    .IDLE_CYCLES (4),
    .CNT_WIDTH   (8),
    .WAKE_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_en_i     (sw_en),
    .auto_en_i   (auto_en),
    .psel_i      (psel),
    .penable_i   (penable),
    .busy_i      (busy),
    .clk_en_o    (clk_en),
    .stall_o     (stall),
    .err_o       (err),
    .all_gated_o (all_gated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] ce;
    logic [7:0] st;
    logic [7:0] er;
    logic       ag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input int c, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, req);
    end
  endtask

  // Monitor: compare whatever the DUT presents this cycle against queued rows.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      $display("cyc=%0d clk_en=%h stall=%h err=%h all_gated=%b", cyc, clk_en, stall, err, all_gated);
      cmp("clk_en", cyc, clk_en, e.ce);
      cmp("stall", cyc, stall, e.st);
      cmp("err", cyc, err, e.er);
      cmp("all_gated", cyc, {7'd0, all_gated}, {7'd0, e.ag});
    end
  end

  task automatic row(input logic r, input logic [7:0] sw, input logic [7:0] au,
                     input logic [7:0] ps, input logic pe, input logic [7:0] bz,
                     input logic [7:0] ce, input logic [7:0] st, input logic [7:0] er,
                     input logic ag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst     = r;
      sw_en   = sw;
      auto_en = au;
      psel    = ps;
      penable = pe;
      busy    = bz;
      exp_q.push_back('{cyc, ce, st, er, ag});
    end
  endtask

  initial begin
    //  rst sw     au     ps     pe    bz    | ce     st     er     ag    n
    // Reset, then idle auto-gating of slave 0 after 4 quiet edges.
    row(1, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 2);
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 4);
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 2);
    // Access to gated slave 0: 3 stalled cycles, clock back one edge after psel.
    row(0, 8'hFF, 8'h01, 8'h01, 0, 8'h00, 8'hFE, 8'h01, 8'h00, 0, 1);
    row(0, 8'hFF, 8'h01, 8'h01, 1, 8'h00, 8'hFF, 8'h01, 8'h00, 0, 2);
    row(0, 8'hFF, 8'h01, 8'h01, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1);
    // busy pulses every third cycle never let the idle count reach its end.
    for (int k = 0; k < 4; k++) begin
      row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h01, 8'hFF, 8'h00, 8'h00, 0, 1);
      row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 2);
    end
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 2);
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 1);
    // Slave 3 switched off by software; its access errors without stalling.
    row(0, 8'hF7, 8'h01, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 1);
    row(0, 8'hF7, 8'h01, 8'h08, 0, 8'h00, 8'hF6, 8'h00, 8'h00, 0, 1);
    row(0, 8'hF7, 8'h01, 8'h08, 1, 8'h00, 8'hF6, 8'h00, 8'h08, 0, 1);
    row(0, 8'hF7, 8'h01, 8'h00, 0, 8'h00, 8'hF6, 8'h00, 8'h00, 0, 1);
    // Software re-enable of slave 3: WAKE for 2 cycles, then RUN.
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hF6, 8'h00, 8'h00, 0, 1);
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 1);
    row(0, 8'hFF, 8'h01, 8'h08, 0, 8'h00, 8'hFE, 8'h08, 8'h00, 0, 1);
    row(0, 8'hFF, 8'h01, 8'h08, 1, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 1);
    row(0, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 1);
    // Everything gated or off -> all_gated; one psel clears it next cycle.
    row(0, 8'hDF, 8'hFF, 8'h00, 0, 8'h00, 8'hFE, 8'h00, 8'h00, 0, 1);
    row(0, 8'hDF, 8'hFF, 8'h00, 0, 8'h00, 8'hDE, 8'h00, 8'h00, 0, 3);
    row(0, 8'hDF, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1);
    row(0, 8'hDF, 8'hFF, 8'h04, 0, 8'h00, 8'h00, 8'h04, 8'h00, 1, 1);
    row(0, 8'hDF, 8'hFF, 8'h04, 1, 8'h00, 8'h04, 8'h04, 8'h00, 0, 1);
    // Reset mid-WAKE forces every clock enable high before the next edge.
    row(1, 8'hDF, 8'hFF, 8'h04, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1);
    row(0, 8'hDF, 8'hFF, 8'h00, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1);
    row(0, 8'hDF, 8'hFF, 8'h20, 1, 8'h00, 8'hDF, 8'h00, 8'h20, 0, 1);
    row(0, 8'hDF, 8'hFF, 8'h00, 0, 8'h00, 8'hDF, 8'h00, 8'h00, 0, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 rows left unchecked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_periph_clk_gate_ctrl.md
Name: apb_periph_clk_gate_ctrl

Overview:
Automatic per-peripheral clock-gating controller for the APB peripheral subsystem. It drives the enable inputs of the per-slave clock-gate cells. It gates a peripheral after a programmable idle period and re-enables the clock when an APB access or peripheral activity arrives. While a clock restarts, it stalls the APB transfer; accesses to software-disabled slaves are terminated with an error.

Parameters:
NUM_SLAVES, 8, number of gated APB slaves (one clock-gate cell each)
IDLE_CYCLES, 64, consecutive quiet cycles before auto-gating; legal range 1..2^CNT_WIDTH-1
CNT_WIDTH, 8, idle counter width
WAKE_CYCLES, 2, cycles of stall after clock re-enable before the slave may respond; legal range 1..15

Ports:
clk  in  1  system clock, ungated
rst  in  1  asynchronous reset, active-high
sw_en_i  in  NUM_SLAVES  software clock enable per slave, from the SoC control register; 0 forces OFF
auto_en_i  in  NUM_SLAVES  allow idle auto-gating per slave
psel_i  in  NUM_SLAVES  decoded APB select per slave
penable_i  in  1  APB penable
busy_i  in  NUM_SLAVES  peripheral internal activity (e.g. UART shifting, timer running)
clk_en_o  out  NUM_SLAVES  enable to clock-gate cell i, registered
stall_o  out  NUM_SLAVES  force pready low for slave i
err_o  out  NUM_SLAVES  force pready=1 and pslverr=1 for slave i
all_gated_o  out  1  every slave is GATED or OFF, registered

Behaviour:
- Per-slave FSM, states OFF, RUN, GATED, WAKE; slaves are independent.
- Reset: state=RUN, idle_cnt=0, wake_cnt=0, clk_en_o=all 1, all_gated_o=0. Combinational outputs follow the RUN state, so stall_o=0 and err_o=0.
- Priority in every state: sw_en_i[i]=0 moves the slave to OFF next cycle and overrides all other conditions.
- Activity term: act = psel_i[i] | busy_i[i].
- RUN:
  - clk_en=1.
  - If act or !auto_en_i[i]: idle_cnt<=0.
  - Otherwise idle_cnt increments and saturates.
  - When quiet and idle_cnt==IDLE_CYCLES-1: go to GATED, idle_cnt<=0.
  - With IDLE_CYCLES=N, clk_en_o falls exactly N clock edges after the last active cycle.
  - Activity in the same cycle as the terminal count: stay in RUN, counter cleared.
- GATED:
  - clk_en=0.
  - If act or !auto_en_i[i]: go to WAKE, wake_cnt<=0.
- WAKE:
  - clk_en=1, registered, so it rises on the WAKE entry edge.
  - wake_cnt increments each cycle; at wake_cnt==WAKE_CYCLES-1 go to RUN with idle_cnt=0.
- OFF:
  - clk_en=0.
  - When sw_en_i[i] rises, go to WAKE. auto_en_i is ignored in OFF.
- stall_o[i] = psel_i[i] & (state==GATED | state==WAKE), combinational.
  - A transfer that hits a gated slave sees pready low for 1 (GATED) + WAKE_CYCLES cycles.
  - The slave responds normally in the first RUN cycle.
- err_o[i] = psel_i[i] & penable_i & state==OFF, combinational; this completes the transfer in one access cycle with an error.
- err_o and stall_o are mutually exclusive by construction.
- all_gated_o is registered: 1 when every slave's next state is GATED or OFF.
- sw_en_i dropping mid-WAKE with psel active: go to OFF; the stalled transfer then terminates via err_o.
- busy_i held high keeps the slave in RUN indefinitely.
- Reset asserted mid-operation returns all slaves to RUN with clocks enabled on the next evaluation; the async reset forces clk_en_o to 1 immediately.

Decomposition:
- Package apb_clk_gate_pkg:
  - state enum cg_state_e {CG_OFF, CG_RUN, CG_GATED, CG_WAKE}, 2 bits
  - default parameter constants
  - function checking the IDLE_CYCLES range against CNT_WIDTH, used by an elaboration assertion
- Sub-module clk_gate_slot: one per-slave FSM with its counters and its clk_en/stall/err outputs, instantiated NUM_SLAVES times in a generate loop.
- The top level adds only the all_gated_o reduction.

Test Plan:
1. Reset, then sw_en=all 1, auto_en=8'h01, IDLE_CYCLES=4, no activity -> clk_en_o[0] falls at cycle 4 after reset release; other bits stay 1; all_gated_o stays 0.
2. Slave 0 GATED, WAKE_CYCLES=2, APB read with psel_i[0]=1 -> stall_o[0] high for 3 cycles; clk_en_o[0] rises 1 cycle after psel; stall drops with the state in RUN.
3. busy_i[0] pulses every 3 cycles with IDLE_CYCLES=4 -> clk_en_o[0] never falls; idle_cnt never exceeds 2.
4. sw_en_i[3]=0, write to slave 3 -> err_o[3]=1 in the penable cycle; clk_en_o[3]=0; stall_o[3]=0.
5. sw_en_i[3] 0->1 -> WAKE; clk_en_o[3]=1 next edge; RUN after 2 cycles.
6. All 8 slaves auto-gated or OFF -> all_gated_o=1; one psel -> all_gated_o=0 next cycle. Assert rst mid-WAKE -> clk_en_o=8'hFF immediately.
